// File: rtl/dtw_ctrl_if.sv
// Control, FIFO, reference-memory and datapath signals of the DTW sequencing controller.
// The controller uses the slave modport; the surrounding system drives the master side.
interface dtw_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 15,
  parameter int FIFO_W  = 32,
  parameter int SQG_MAX = 1024
);
  localparam int LEN_W = $clog2(SQG_MAX + 1);

  logic              start;
  logic [1:0]        op_mode;
  logic [ADDR_W:0]   ref_len;
  logic [LEN_W-1:0]  sqg_len;
  logic [DATA_W-1:0] threshold;
  logic              abort;
  logic              busy;
  logic              load_done;
  logic              err;
  logic [31:0]       query_count;
  logic              src_rden;
  logic              src_empty;
  logic [FIFO_W-1:0] src_data;
  logic              sink_wren;
  logic              sink_full;
  logic [FIFO_W-1:0] sink_data;
  logic              ref_wren;
  logic [ADDR_W-1:0] ref_waddr;
  logic [DATA_W-1:0] ref_wdata;
  logic              dp_clear;
  logic              dp_sample_valid;
  logic [DATA_W-1:0] dp_sample;
  logic              dp_done;
  logic [DATA_W-1:0] dp_minval;
  logic [31:0]       dp_position;

  modport slave (
    input  start, op_mode, ref_len, sqg_len, threshold, abort,
           src_empty, src_data, sink_full, dp_done, dp_minval, dp_position,
    output busy, load_done, err, query_count, src_rden, sink_wren, sink_data,
           ref_wren, ref_waddr, ref_wdata, dp_clear, dp_sample_valid, dp_sample
  );

  modport master (
    output start, op_mode, ref_len, sqg_len, threshold, abort,
           src_empty, src_data, sink_full, dp_done, dp_minval, dp_position,
    input  busy, load_done, err, query_count, src_rden, sink_wren, sink_data,
           ref_wren, ref_waddr, ref_wdata, dp_clear, dp_sample_valid, dp_sample
  );
endinterface

// File: rtl/dtw_ctrl.sv
// DTW sequencing controller: reference load/clear, query streaming into an external
// datapath, and 3-word result serialisation into the sink FIFO.
module dtw_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 15,
  parameter int FIFO_W  = 32,
  parameter int SQG_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  dtw_ctrl_if.slave  bus
);
  localparam int LEN_W = $clog2(SQG_MAX + 1);
  localparam logic [ADDR_W:0]  REF_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] SQG_MX  = LEN_W'(SQG_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, QID, STREAM, WAIT, EMIT} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_ref_len, r_wcnt;
  logic [LEN_W-1:0]  r_sqg_len, r_scnt;
  logic [FIFO_W-1:0] r_qid, r_pos;
  logic [DATA_W-1:0] r_minval;
  logic [1:0]        r_widx;
  logic              r_load_done, r_err, r_ref_wren, r_dp_clear, r_dp_sv;
  logic [31:0]       r_qcnt;
  logic [ADDR_W-1:0] r_ref_waddr;
  logic [DATA_W-1:0] r_ref_wdata, r_dp_sample;

  logic              w_pop, w_wr, w_ref_ok, w_sqg_ok;
  logic [FIFO_W-1:0] w_res, w_sink_data;

  assign w_ref_ok = (bus.ref_len != '0) && (bus.ref_len <= REF_MAX);
  assign w_sqg_ok = (bus.sqg_len != '0) && (bus.sqg_len <= SQG_MX);

  // Abort suppresses both the pop and the sink write of its cycle.
  assign w_pop = !bus.src_empty && !bus.abort &&
                 ((r_state == LOAD) || (r_state == QID) ||
                  ((r_state == STREAM) && (r_scnt < r_sqg_len)));
  assign w_wr  = (r_state == EMIT) && !bus.sink_full && !bus.abort;

  always_comb begin
    w_res = '0;
    w_res[DATA_W-1:0] = r_minval;
    w_res[FIFO_W-1]   = (r_minval <= bus.threshold);
  end

  always_comb begin
    w_sink_data = '0;
    if (r_state == EMIT) begin
      case (r_widx)
        2'd0:    w_sink_data = r_qid;
        2'd1:    w_sink_data = r_pos;
        default: w_sink_data = w_res;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ref_len   <= '0;
      r_wcnt      <= '0;
      r_sqg_len   <= '0;
      r_scnt      <= '0;
      r_qid       <= '0;
      r_pos       <= '0;
      r_minval    <= '0;
      r_widx      <= '0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_ref_wren  <= 1'b0;
      r_dp_clear  <= 1'b0;
      r_dp_sv     <= 1'b0;
      r_qcnt      <= '0;
      r_ref_waddr <= '0;
      r_ref_wdata <= '0;
      r_dp_sample <= '0;
    end else begin
      r_err      <= 1'b0;
      r_dp_clear <= 1'b0;
      r_ref_wren <= w_pop && (r_state == LOAD);
      r_dp_sv    <= w_pop && (r_state == STREAM);
      if (w_pop && (r_state == LOAD)) begin
        r_ref_waddr <= r_wcnt[ADDR_W-1:0];
        r_ref_wdata <= bus.src_data[DATA_W-1:0];
      end
      if (w_pop && (r_state == STREAM))
        r_dp_sample <= bus.src_data[DATA_W-1:0];

      if (bus.abort && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
        if (r_state == LOAD) r_load_done <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (bus.start) begin
            case (bus.op_mode)
              2'd0: if (r_load_done && w_sqg_ok) begin
                r_state    <= QID;
                r_sqg_len  <= bus.sqg_len;
                r_scnt     <= '0;
                r_dp_clear <= 1'b1;
              end else r_err <= 1'b1;
              2'd1: if (!r_load_done && w_ref_ok) begin
                r_state   <= LOAD;
                r_ref_len <= bus.ref_len;
                r_wcnt    <= '0;
              end else r_err <= 1'b1;
              2'd2:    r_load_done <= 1'b0;
              default: r_err <= 1'b1;
            endcase
          end
          // load_done rises together with the final ref_wren pulse.
          LOAD: if (w_pop) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == r_ref_len - (ADDR_W+1)'(1)) begin
              r_state     <= IDLE;
              r_load_done <= 1'b1;
            end
          end
          QID: if (w_pop) begin
            r_qid   <= bus.src_data;
            r_state <= STREAM;
          end
          STREAM: if (w_pop) begin
            r_scnt <= r_scnt + 1'b1;
            if (r_scnt == r_sqg_len - LEN_W'(1)) r_state <= WAIT;
          end
          WAIT: if (bus.dp_done) begin
            r_minval <= bus.dp_minval;
            r_pos    <= FIFO_W'(bus.dp_position);
            r_widx   <= '0;
            r_state  <= EMIT;
          end
          EMIT: if (w_wr) begin
            r_widx <= r_widx + 1'b1;
            if (r_widx == 2'd2) begin
              r_qcnt  <= r_qcnt + 32'd1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy            = (r_state != IDLE);
  assign bus.load_done       = r_load_done;
  assign bus.err             = r_err;
  assign bus.query_count     = r_qcnt;
  assign bus.src_rden        = w_pop;
  assign bus.sink_wren       = w_wr;
  assign bus.sink_data       = w_sink_data;
  assign bus.ref_wren        = r_ref_wren;
  assign bus.ref_waddr       = r_ref_waddr;
  assign bus.ref_wdata       = r_ref_wdata;
  assign bus.dp_clear        = r_dp_clear;
  assign bus.dp_sample_valid = r_dp_sv;
  assign bus.dp_sample       = r_dp_sample;
endmodule

// File: tb/tb_dtw_ctrl.sv
// Directed bench for dtw_ctrl: FIFO and datapath models with posedge loggers,
// scenario tasks check against hand-computed values.
module tb_dtw_ctrl;
  localparam int DATA_W = 16, ADDR_W = 15, FIFO_W = 32, SQG_MAX = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtw_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_W(FIFO_W), .SQG_MAX(SQG_MAX)) bus ();
  dtw_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_W(FIFO_W), .SQG_MAX(SQG_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_fail = 0;

  // Source FIFO model (first-word-fall-through)
  logic [31:0] src_mem [0:255];
  int   src_wp = 0, src_rp = 0;
  logic stall_empty = 1'b0, flush = 1'b0;
  assign bus.src_empty = (src_rp == src_wp) || stall_empty;
  assign bus.src_data  = src_mem[src_rp[7:0]];

  // Loggers
  int n_ref = 0, n_smp = 0, n_snk = 0, n_pop = 0, n_clr = 0, n_bad = 0;
  logic [14:0] ref_a [0:255];
  logic [15:0] ref_d [0:255];
  logic [15:0] smp   [0:255];
  logic [31:0] snk   [0:255];
  logic        ld_at_wr = 1'b0;

  always @(posedge clk) begin
    if (flush) src_rp <= src_wp;
    else if (bus.src_rden) src_rp <= src_rp + 1;
    if (bus.src_rden) n_pop <= n_pop + 1;
    if (bus.ref_wren) begin
      ref_a[n_ref[7:0]] <= bus.ref_waddr;
      ref_d[n_ref[7:0]] <= bus.ref_wdata;
      ld_at_wr <= bus.load_done;
      n_ref <= n_ref + 1;
    end
    if (bus.dp_sample_valid) begin
      smp[n_smp[7:0]] <= bus.dp_sample;
      n_smp <= n_smp + 1;
    end
    if (bus.sink_wren) begin
      snk[n_snk[7:0]] <= bus.sink_data;
      n_snk <= n_snk + 1;
    end
    if (bus.sink_wren && bus.sink_full) n_bad <= n_bad + 1;
    if (bus.dp_clear) n_clr <= n_clr + 1;
  end

  task automatic push(input logic [31:0] w);
    src_mem[src_wp[7:0]] = w;
    src_wp++;
  endtask

  task automatic do_flush;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  // Start strobe during one cycle; returns at the negedge of the following cycle.
  task automatic go(input logic [1:0] m, input logic [15:0] rl, input logic [10:0] sl);
    @(negedge clk);
    bus.start = 1'b1; bus.op_mode = m; bus.ref_len = rl; bus.sqg_len = sl;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if ({bus.busy, bus.load_done, bus.err, bus.src_rden, bus.sink_wren, bus.ref_wren,
                  bus.dp_clear, bus.dp_sample_valid} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000000", {bus.busy, bus.load_done, bus.err,
        bus.src_rden, bus.sink_wren, bus.ref_wren, bus.dp_clear, bus.dp_sample_valid}); end
    n_cmp++; if (bus.query_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_qcount: got %0h want 0", bus.query_count); end
    n_cmp++; if (bus.sink_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_sink_data: got %0h want 0", bus.sink_data); end
    n_cmp++; if ({bus.ref_waddr, bus.ref_wdata, bus.dp_sample} !== 47'd0) begin
      n_fail++; $display("FAIL reset_data_regs: got %0h want 0", {bus.ref_waddr, bus.ref_wdata, bus.dp_sample}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_errors;
    logic [1:0]  em [4];
    logic [15:0] erl [4];
    logic [10:0] esl [4];
    int p0;
    em  = '{2'd0, 2'd1, 2'd3, 2'd1};
    erl = '{16'd4, 16'd0, 16'd4, 16'd32769};
    esl = '{11'd3, 11'd3, 11'd3, 11'd3};
    push(32'hDEAD);
    p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      go(em[i], erl[i], esl[i]);
      n_cmp++; if ({bus.err, bus.busy} !== 2'b10) begin
        n_fail++; $display("FAIL err_pulse[%0d]: got err,busy=%b want 10", i, {bus.err, bus.busy}); end
      @(negedge clk);
      n_cmp++; if ({bus.err, bus.busy} !== 2'b00) begin
        n_fail++; $display("FAIL err_one_cycle[%0d]: got err,busy=%b want 00", i, {bus.err, bus.busy}); end
    end
    n_cmp++; if (n_pop != p0) begin
      n_fail++; $display("FAIL err_no_pop: got %0d pops want 0", n_pop - p0); end
    do_flush;
  endtask

  task automatic test_load(input logic [15:0] base);
    int p, nb;
    for (int i = 0; i < 4; i++) push({16'h0, base + 16'(i)});
    p = n_ref;
    go(2'd1, 16'd4, 11'd0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) nb++;
      @(negedge clk);
    end
    n_cmp++; if (nb != 4) begin
      n_fail++; $display("FAIL load_busy_cycles: got %0d want 4", nb); end
    n_cmp++; if (n_ref - p != 4) begin
      n_fail++; $display("FAIL load_wren_count: got %0d want 4", n_ref - p); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({ref_a[p+i], ref_d[p+i]} !== {15'(i), base + 16'(i)}) begin
        n_fail++; $display("FAIL load_word[%0d]: got addr %0d data %0d want addr %0d data %0d",
                           i, ref_a[p+i], ref_d[p+i], i, base + 16'(i)); end
    end
    n_cmp++; if (ld_at_wr !== 1'b1 || bus.load_done !== 1'b1) begin
      n_fail++; $display("FAIL load_done: got at_last_wr=%b now=%b want 1,1", ld_at_wr, bus.load_done); end
  endtask

  task automatic test_errors_loaded;
    logic [1:0]  em [2];
    logic [10:0] esl [2];
    int p0;
    em  = '{2'd0, 2'd1};
    esl = '{11'd1025, 11'd3};
    push(32'hBEEF);
    p0 = n_pop;
    for (int i = 0; i < 2; i++) begin
      go(em[i], 16'd4, esl[i]);
      n_cmp++; if ({bus.err, bus.busy} !== 2'b10) begin
        n_fail++; $display("FAIL err_loaded[%0d]: got err,busy=%b want 10", i, {bus.err, bus.busy}); end
      @(negedge clk);
    end
    n_cmp++; if (n_pop != p0 || bus.load_done !== 1'b1) begin
      n_fail++; $display("FAIL err_loaded_state: got pops %0d load_done %b want 0,1", n_pop - p0, bus.load_done); end
    do_flush;
  endtask

  task automatic test_query(input logic [31:0] qid, input logic [15:0] mv, input logic [31:0] pos,
                            input logic [15:0] thr, input bit stall, input bit full,
                            input logic [31:0] exp_w2, input logic [31:0] exp_qc);
    int bs, bk, bc, cyc;
    bit to;
    push(qid); push(32'd1); push(32'd2); push(32'd3);
    bs = n_smp; bk = n_snk; bc = n_clr;
    bus.dp_done = 1'b0; bus.dp_minval = mv; bus.dp_position = pos; bus.threshold = thr;
    go(2'd0, 16'd0, 11'd3);
    n_cmp++; if ({bus.dp_clear, bus.src_rden} !== 2'b11) begin
      n_fail++; $display("FAIL q_clear_pop: got clear,rden=%b want 11", {bus.dp_clear, bus.src_rden}); end
    to = 1'b1; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (n_smp - bs == 3) begin to = 1'b0; cyc = i; break; end
      @(negedge clk);
      if (stall) stall_empty = !stall_empty;
    end
    stall_empty = 1'b0;
    n_cmp++; if (to) begin
      n_fail++; $display("FAIL q_samples_timeout: got %0d samples want 3", n_smp - bs); end
    if (!stall) begin
      n_cmp++; if (cyc != 5) begin
        n_fail++; $display("FAIL q_sample_latency: got %0d want 5", cyc); end
    end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || n_snk != bk) begin
      n_fail++; $display("FAIL q_wait: got busy %b writes %0d want 1,0", bus.busy, n_snk - bk); end
    bus.dp_done = 1'b1;
    if (full) begin
      bus.sink_full = 1'b1;
      repeat (6) @(negedge clk);
      bus.sink_full = 1'b0;
    end
    to = 1'b1; cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) begin to = 1'b0; cyc = i; break; end
      @(negedge clk);
    end
    bus.dp_done = 1'b0;
    n_cmp++; if (to) begin
      n_fail++; $display("FAIL q_emit_timeout: got busy %b want 0", bus.busy); end
    if (!full) begin
      n_cmp++; if (cyc != 4) begin
        n_fail++; $display("FAIL q_emit_latency: got %0d want 4", cyc); end
    end
    n_cmp++; if (n_smp - bs != 3 || {smp[bs], smp[bs+1], smp[bs+2]} !== {16'd1, 16'd2, 16'd3}) begin
      n_fail++; $display("FAIL q_samples: got n=%0d %0d,%0d,%0d want 3: 1,2,3",
                         n_smp - bs, smp[bs], smp[bs+1], smp[bs+2]); end
    n_cmp++; if (n_snk - bk != 3) begin
      n_fail++; $display("FAIL q_sink_count: got %0d want 3", n_snk - bk); end
    n_cmp++; if (snk[bk] !== qid) begin
      n_fail++; $display("FAIL q_word0: got %h want %h", snk[bk], qid); end
    n_cmp++; if (snk[bk+1] !== pos) begin
      n_fail++; $display("FAIL q_word1: got %h want %h", snk[bk+1], pos); end
    n_cmp++; if (snk[bk+2] !== exp_w2) begin
      n_fail++; $display("FAIL q_word2: got %h want %h", snk[bk+2], exp_w2); end
    n_cmp++; if (bus.query_count !== exp_qc) begin
      n_fail++; $display("FAIL q_count: got %0d want %0d", bus.query_count, exp_qc); end
    n_cmp++; if (n_bad != 0 || n_clr - bc != 1) begin
      n_fail++; $display("FAIL q_full_clear: got writes-while-full %0d clears %0d want 0,1", n_bad, n_clr - bc); end
  endtask

  task automatic test_abort;
    int p, pp;
    go(2'd2, 16'd0, 11'd0);
    n_cmp++; if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_ref: got load_done %b busy %b want 0,0", bus.load_done, bus.busy); end
    for (int i = 0; i < 4; i++) push(32'd50 + 32'(i));
    p = n_ref; pp = n_pop;
    go(2'd1, 16'd4, 11'd0);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    n_cmp++; if (bus.src_rden !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_pop: got rden %b want 0", bus.src_rden); end
    @(negedge clk);
    bus.abort = 1'b0;
    n_cmp++; if ({bus.busy, bus.err, bus.load_done} !== 3'b010) begin
      n_fail++; $display("FAIL abort_state: got busy,err,ld=%b want 010", {bus.busy, bus.err, bus.load_done}); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b0 || n_ref - p != 2 || n_pop - pp != 2) begin
      n_fail++; $display("FAIL abort_counts: got err %b wrens %0d pops %0d want 0,2,2", bus.err, n_ref - p, n_pop - pp); end
    n_cmp++; if (bus.query_count !== 32'd3) begin
      n_fail++; $display("FAIL abort_qcount: got %0d want 3", bus.query_count); end
    do_flush;
    go(2'd2, 16'd0, 11'd0);
    test_load(16'd20);
    test_query(32'h77, 16'hFFFF, 32'd0, 16'hFFFF, 1'b0, 1'b0, 32'h8000FFFF, 32'd4);
  endtask

  task automatic test_async_reset;
    push(32'h99); push(32'd1);
    go(2'd0, 16'd0, 11'd3);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || bus.query_count !== 32'd4) begin
      n_fail++; $display("FAIL pre_reset: got busy %b qcount %0d want 1,4", bus.busy, bus.query_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.load_done, bus.err, bus.src_rden, bus.sink_wren, bus.ref_wren,
                  bus.dp_clear, bus.dp_sample_valid} !== 8'h00 || bus.query_count !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got flags %b qcount %0d want 00000000,0", {bus.busy, bus.load_done,
        bus.err, bus.src_rden, bus.sink_wren, bus.ref_wren, bus.dp_clear, bus.dp_sample_valid}, bus.query_count); end
    n_cmp++; if ({bus.sink_data, bus.ref_waddr, bus.ref_wdata, bus.dp_sample} !== 79'd0) begin
      n_fail++; $display("FAIL async_reset_data: got %0h want 0", {bus.sink_data, bus.ref_waddr, bus.ref_wdata, bus.dp_sample}); end
    @(negedge clk); rst = 1'b0;
    do_flush;
  endtask

  initial begin
    bus.start = 1'b0; bus.op_mode = 2'd0; bus.ref_len = '0; bus.sqg_len = '0;
    bus.threshold = '0; bus.abort = 1'b0; bus.sink_full = 1'b0;
    bus.dp_done = 1'b0; bus.dp_minval = '0; bus.dp_position = '0;
    test_reset;
    test_errors;
    test_load(16'd10);
    test_errors_loaded;
    test_query(32'hA5, 16'd7, 32'd42, 16'd7, 1'b0, 1'b0, 32'h80000007, 32'd1);
    test_query(32'hA5, 16'd7, 32'd42, 16'd7, 1'b1, 1'b1, 32'h80000007, 32'd2);
    test_query(32'h3C, 16'd7, 32'h12345678, 16'd6, 1'b0, 1'b0, 32'h00000007, 32'd3);
    test_abort;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
